// File: rtl/player_datapath.sv
// Player-ship datapath: owns the vertical anchor and emits one registered VGA pixel write per cycle.
// Optional boundary status outputs (at_top, at_bottom, bump) are built when PLAYER_DP_BOUND_STATUS_EN is defined.
module player_datapath #(
    parameter logic [7:0] X_POS   = 8'd8,
    parameter logic [6:0] Y_START = 7'd58,
    parameter logic [6:0] Y_MIN   = 7'd0,
    parameter logic [6:0] Y_MAX   = 7'd117
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       y_pos_mod,
    input  logic       y_neg_mod,
    input  logic       add_x,
    input  logic [1:0] add_y,
    input  logic [2:0] colour_in,
    input  logic       write_en,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic [6:0] player_y
`ifdef PLAYER_DP_BOUND_STATUS_EN
    ,
    output logic       at_top,
    output logic       at_bottom,
    output logic       bump
`endif
);

    // One-row step toward the requested direction, held at the legal limits.
    function automatic logic [6:0] clamp_move(input logic [6:0] y,
                                              input logic       up,
                                              input logic       down);
        logic [6:0] r;
        r = y;
        if (up && !down && (y > Y_MIN))
            r = y - 7'd1;
        else if (down && !up && (y < Y_MAX))
            r = y + 7'd1;
        return r;
    endfunction

    // Row offset 3 does not exist in the sprite; fold it onto the last row.
    function automatic logic [1:0] sat_row(input logic [1:0] row);
        return (row == 2'd3) ? 2'd2 : row;
    endfunction

    function automatic logic move_blocked(input logic [6:0] y,
                                          input logic       up,
                                          input logic       down);
        return (up && !down && (y == Y_MIN)) || (down && !up && (y == Y_MAX));
    endfunction

    logic [6:0] anchor_y_p1;
    logic [6:0] next_y_p0;
    logic [7:0] x_p1;
    logic [6:0] y_p1;
    logic [2:0] colour_p1;
    logic       vld_p1;

    // ---- stage p0: strobes in, anchor and pixel address resolved combinationally
    always_comb begin
        next_y_p0 = clamp_move(anchor_y_p1, y_pos_mod, y_neg_mod);
    end

    // ---- stage p1: registered anchor and pixel write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            anchor_y_p1 <= Y_START;
            x_p1        <= 8'd0;
            y_p1        <= 7'd0;
            colour_p1   <= 3'd0;
            vld_p1      <= 1'b0;
        end else begin
            anchor_y_p1 <= next_y_p0;
            x_p1        <= X_POS + {7'd0, add_x};
            y_p1        <= next_y_p0 + {5'd0, sat_row(add_y)};
            colour_p1   <= colour_in;
            vld_p1      <= write_en;
        end
    end

    assign x_out      = x_p1;
    assign y_out      = y_p1;
    assign colour_out = colour_p1;
    assign plot       = vld_p1;
    assign player_y   = anchor_y_p1;

`ifdef PLAYER_DP_BOUND_STATUS_EN
    logic at_top_p1;
    logic at_bottom_p1;
    logic bump_p1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            at_top_p1    <= (Y_START == Y_MIN);
            at_bottom_p1 <= (Y_START == Y_MAX);
            bump_p1      <= 1'b0;
        end else begin
            at_top_p1    <= (next_y_p0 == Y_MIN);
            at_bottom_p1 <= (next_y_p0 == Y_MAX);
            bump_p1      <= move_blocked(anchor_y_p1, y_pos_mod, y_neg_mod);
        end
    end

    assign at_top    = at_top_p1;
    assign at_bottom = at_bottom_p1;
    assign bump      = bump_p1;
`endif

endmodule
